// File: rtl/sc_selector_gen.sv
// sc_selector_gen
// ---------------------------------------------------------------------------
// Multi-lane bit-select sequencer for the bit-serial stochastic-computing
// datapath. For a precision n latched at start, it walks one stream of 2^n
// cycles. Each cycle it tells every lane's SN generator which binary operand
// bit to emit, or tells it to emit 0.
//
// Bit n-1-k is selected when the step value c+1 has k trailing zeros. Over
// the 2^n steps, bit n-1-j is therefore selected 2^(n-1-j) times. The single
// step where c+1 == 2^n becomes the zero slot. Lane i runs the same walk
// rotated by i steps so that concurrent generators stay decorrelated.
//
// Build option:
//   SC_SEL_WRAP_EN - continuous mode. The stream wraps back to step 0 with
//                    the same n. done pulses once per completed stream. The
//                    block stays busy until reset. Without this macro the
//                    block runs one-shot: RUN -> DONE -> IDLE.
//
// Ports:
//   clock        in   system clock
//   reset        in   synchronous, active-high reset
//   start        in   one-cycle request to begin a stream (IDLE only)
//   prec         in   requested precision n, clamped to 1..MAX_BITS
//   enable       in   advance permission; low stalls the stream
//   selector     out  lane i at [i*SEL_W +: SEL_W], operand bit index to emit
//   zero_select  out  lane i forces its stream bit to 0 this cycle
//   valid        out  selector/zero_select meaningful this cycle
//   busy         out  stream in progress
//   done         out  one-cycle pulse after the final stream cycle
// ---------------------------------------------------------------------------
module sc_selector_gen #(
  parameter int MAX_BITS  = 8,
  parameter int SEL_W     = $clog2(MAX_BITS),
  parameter int NUM_LANES = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [$clog2(MAX_BITS+1)-1:0] prec,
  input  logic                          enable,
  output logic [NUM_LANES*SEL_W-1:0]    selector,
  output logic [NUM_LANES-1:0]          zero_select,
  output logic                          valid,
  output logic                          busy,
  output logic                          done
);

  localparam int PREC_W = $clog2(MAX_BITS + 1);
  // One bit wider than MAX_BITS so that c+1 == 2^MAX_BITS stays representable.
  localparam int CNT_W  = MAX_BITS + 1;
  localparam logic [PREC_W-1:0] MAX_N = PREC_W'(MAX_BITS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_count, w_count_nxt;
  logic [PREC_W-1:0]  r_n, w_n_nxt;

  logic [CNT_W-1:0]   w_last;
  logic               w_adv;
  logic               w_at_last;
  logic [CNT_W-1:0]   w_c;
  logic [PREC_W-1:0]  w_k;

  // Map a requested precision onto the supported range 1..MAX_BITS.
  function automatic logic [PREC_W-1:0] f_clamp(input logic [PREC_W-1:0] p);
    logic [PREC_W-1:0] n;
    if (p == '0)
      n = PREC_W'(1);
    else if (p > MAX_N)
      n = MAX_N;
    else
      n = p;
    return n;
  endfunction

  // Trailing-zero count. The caller always passes a nonzero value.
  function automatic logic [PREC_W-1:0] f_tz(input logic [CNT_W-1:0] v);
    logic [PREC_W-1:0] tz;
    tz = '0;
    for (int b = CNT_W - 1; b >= 0; b--) begin
      if (v[b]) tz = PREC_W'(b);
    end
    return tz;
  endfunction

  // 2^n - 1 is both the final count value and the mod-2^n mask.
  assign w_last    = (CNT_W'(1) << r_n) - CNT_W'(1);
  assign w_adv     = (r_state == S_RUN) && enable;
  assign w_at_last = (r_count == w_last);

  // ---- state / counter registers ----
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_n     <= PREC_W'(1);
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      r_n     <= w_n_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_n_nxt     = r_n;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_n_nxt     = f_clamp(prec);
          w_count_nxt = '0;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        // A start seen here is deliberately ignored, and prec is not re-latched.
        if (enable) begin
          if (w_at_last) begin
            w_count_nxt = '0;
`ifdef SC_SEL_WRAP_EN
            w_state_nxt = S_RUN;
`else
            w_state_nxt = S_DONE;
`endif
          end else begin
            w_count_nxt = r_count + CNT_W'(1);
          end
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef SC_SEL_WRAP_EN
  logic r_wrap_done;

  // done marks the step just after each wrap.
  always_ff @(posedge clock) begin
    if (reset)
      r_wrap_done <= 1'b0;
    else
      r_wrap_done <= w_adv && w_at_last;
  end

  assign done = r_wrap_done;
`else
  assign done = (r_state == S_DONE);
`endif

  assign busy  = (r_state == S_RUN);
  assign valid = w_adv;

  // ---- per-lane selection, combinational from r_count / r_n ----
  always_comb begin
    selector    = '0;
    zero_select = '0;
    w_c         = '0;
    w_k         = '0;
    if (w_adv) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        w_c = (r_count + CNT_W'(l)) & w_last;
        w_k = f_tz(w_c + CNT_W'(1));
        if (w_k == r_n)
          zero_select[l] = 1'b1;
        else
          selector[l*SEL_W +: SEL_W] = SEL_W'(r_n - PREC_W'(1) - w_k);
      end
    end
  end

endmodule

// File: tb/tb_sc_selector_gen.sv
// tb_sc_selector_gen
// ---------------------------------------------------------------------------
// Directed self-checking bench for sc_selector_gen with default parameters
// (MAX_BITS=8, SEL_W=3, NUM_LANES=4). Expected sequences are hand-derived
// from the trailing-zero rule. Inputs change 1 ns after the rising edge, and
// outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_sc_selector_gen;

  logic        clock;
  logic        reset;
  logic        start;
  logic [3:0]  prec;
  logic        enable;
  logic [11:0] selector;
  logic [3:0]  zero_select;
  logic        valid;
  logic        busy;
  logic        done;

  int n_checks;
  int n_errors;

  // n=3 sequences for lane 0 and lane 1 (lane 1 is rotated by one step).
  logic [2:0] exp_s0 [8] = '{3'd2, 3'd1, 3'd2, 3'd0, 3'd2, 3'd1, 3'd2, 3'd0};
  logic       exp_z0 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [2:0] exp_s1 [8] = '{3'd1, 3'd2, 3'd0, 3'd2, 3'd1, 3'd2, 3'd0, 3'd2};
  logic       exp_z1 [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  sc_selector_gen #(
    .MAX_BITS  (8),
    .SEL_W     (3),
    .NUM_LANES (4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .prec        (prec),
    .enable      (enable),
    .selector    (selector),
    .zero_select (zero_select),
    .valid       (valid),
    .busy        (busy),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic do_reset();
    reset  = 1'b1;
    start  = 1'b0;
    enable = 1'b0;
    prec   = 4'd0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  task automatic launch(input logic [3:0] p);
    enable = 1'b1;
    prec   = p;
    start  = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    start  = 1'b1;
    enable = 1'b1;
    prec   = 4'd3;
    @(posedge clock);
    @(negedge clock);
    n_checks++;
    if ({busy, valid, done} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_ctrl_in_reset got busy/valid/done=%b want 000", {busy, valid, done});
    end
    @(posedge clock);
    #1 reset = 1'b0;
    start = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({busy, valid, done} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_ctrl got busy/valid/done=%b want 000", {busy, valid, done});
    end
    n_checks++;
    if (selector !== 12'd0 || zero_select !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_outputs got sel=%h zs=%b want 0/0", selector, zero_select);
    end
  endtask

  task automatic test_basic();
    int zc[4];
    for (int l = 0; l < 4; l++) zc[l] = 0;
    do_reset();
    launch(4'd3);
    for (int j = 0; j < 8; j++) begin
      @(negedge clock);
      n_checks++;
      if ({valid, busy, done} !== 3'b110) begin
        n_errors++;
        $display("FAIL basic_ctrl j=%0d got valid/busy/done=%b want 110", j, {valid, busy, done});
      end
      n_checks++;
      if (selector[2:0] !== exp_s0[j] || zero_select[0] !== exp_z0[j]) begin
        n_errors++;
        $display("FAIL basic_lane0 j=%0d got sel=%0d zs=%b want sel=%0d zs=%b",
                 j, selector[2:0], zero_select[0], exp_s0[j], exp_z0[j]);
      end
      n_checks++;
      if (selector[5:3] !== exp_s1[j] || zero_select[1] !== exp_z1[j]) begin
        n_errors++;
        $display("FAIL basic_lane1 j=%0d got sel=%0d zs=%b want sel=%0d zs=%b",
                 j, selector[5:3], zero_select[1], exp_s1[j], exp_z1[j]);
      end
      for (int l = 0; l < 4; l++) zc[l] += int'(zero_select[l]);
      @(posedge clock);
      #1;
    end
    @(negedge clock);
    n_checks++;
    if ({done, busy, valid} !== 3'b100) begin
      n_errors++;
      $display("FAIL basic_done got done/busy/valid=%b want 100", {done, busy, valid});
    end
    n_checks++;
    if (selector !== 12'd0 || zero_select !== 4'd0) begin
      n_errors++;
      $display("FAIL basic_done_outputs got sel=%h zs=%b want 0/0", selector, zero_select);
    end
    for (int l = 0; l < 4; l++) begin
      n_checks++;
      if (zc[l] !== 1) begin
        n_errors++;
        $display("FAIL basic_zero_count lane=%0d got %0d want 1", l, zc[l]);
      end
    end
    @(posedge clock);
    #1;
    @(negedge clock);
    n_checks++;
    if ({done, busy} !== 2'b00) begin
      n_errors++;
      $display("FAIL basic_idle got done/busy=%b want 00", {done, busy});
    end
  endtask

  task automatic test_stall();
    int  vcnt;
    logic saw_done;
    vcnt     = 0;
    saw_done = 1'b0;
    do_reset();
    launch(4'd3);
    for (int cyc = 0; cyc < 30; cyc++) begin
      enable = !(cyc >= 2 && cyc <= 4);
      @(negedge clock);
      if (valid) vcnt++;
      if (cyc >= 2 && cyc <= 4) begin
        n_checks++;
        if (valid !== 1'b0 || busy !== 1'b1 || selector !== 12'd0 || zero_select !== 4'd0) begin
          n_errors++;
          $display("FAIL stall_hold cyc=%0d got valid=%b busy=%b sel=%h zs=%b want 0 1 0 0",
                   cyc, valid, busy, selector, zero_select);
        end
      end
      if (cyc == 5) begin
        n_checks++;
        if (valid !== 1'b1 || selector[2:0] !== 3'd2) begin
          n_errors++;
          $display("FAIL stall_resume got valid=%b sel0=%0d want 1 2", valid, selector[2:0]);
        end
      end
      if (done) saw_done = 1'b1;
      @(posedge clock);
      #1;
      if (saw_done) break;
    end
    enable = 1'b1;
    n_checks++;
    if (saw_done !== 1'b1) begin
      n_errors++;
      $display("FAIL stall_timeout got done_seen=%b want 1", saw_done);
    end
    n_checks++;
    if (vcnt !== 8) begin
      n_errors++;
      $display("FAIL stall_valid_count got %0d want 8", vcnt);
    end
  endtask

  task automatic test_prec_clamp();
    int   vcnt;
    int   sevens;
    int   zeros;
    logic saw_done;
    // prec=0 behaves as n=1
    do_reset();
    launch(4'd0);
    @(negedge clock);
    n_checks++;
    if (valid !== 1'b1 || selector[2:0] !== 3'd0 || zero_select[0] !== 1'b0) begin
      n_errors++;
      $display("FAIL clamp0_step0 got valid=%b sel0=%0d zs0=%b want 1 0 0",
               valid, selector[2:0], zero_select[0]);
    end
    @(posedge clock);
    #1;
    @(negedge clock);
    n_checks++;
    if (valid !== 1'b1 || zero_select[0] !== 1'b1) begin
      n_errors++;
      $display("FAIL clamp0_step1 got valid=%b zs0=%b want 1 1", valid, zero_select[0]);
    end
    @(posedge clock);
    #1;
    @(negedge clock);
    n_checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL clamp0_done got done=%b busy=%b want 1 0", done, busy);
    end
    // prec=12 clamps to n=8
    @(posedge clock);
    #1;
    vcnt     = 0;
    sevens   = 0;
    zeros    = 0;
    saw_done = 1'b0;
    launch(4'd12);
    for (int cyc = 0; cyc < 300; cyc++) begin
      @(negedge clock);
      if (valid) vcnt++;
      if (valid && !zero_select[0] && selector[2:0] == 3'd7) sevens++;
      if (valid && zero_select[0]) zeros++;
      if (done) saw_done = 1'b1;
      @(posedge clock);
      #1;
      if (saw_done) break;
    end
    n_checks++;
    if (saw_done !== 1'b1 || vcnt !== 256) begin
      n_errors++;
      $display("FAIL clamp12_length got done_seen=%b valid_cycles=%0d want 1 256", saw_done, vcnt);
    end
    n_checks++;
    if (sevens !== 128) begin
      n_errors++;
      $display("FAIL clamp12_sel7_count got %0d want 128", sevens);
    end
    n_checks++;
    if (zeros !== 1) begin
      n_errors++;
      $display("FAIL clamp12_zero_count got %0d want 1", zeros);
    end
  endtask

  task automatic test_ignore_start();
    do_reset();
    launch(4'd3);
    for (int cyc = 0; cyc < 11; cyc++) begin
      start = (cyc == 3 || cyc == 8);
      prec  = 4'd1;
      @(negedge clock);
      if (cyc < 8) begin
        n_checks++;
        if (valid !== 1'b1 || selector[2:0] !== exp_s0[cyc] || zero_select[0] !== exp_z0[cyc]) begin
          n_errors++;
          $display("FAIL ignore_seq cyc=%0d got valid=%b sel0=%0d zs0=%b want 1 %0d %b",
                   cyc, valid, selector[2:0], zero_select[0], exp_s0[cyc], exp_z0[cyc]);
        end
      end else if (cyc == 8) begin
        n_checks++;
        if (done !== 1'b1) begin
          n_errors++;
          $display("FAIL ignore_done got done=%b want 1", done);
        end
      end else begin
        n_checks++;
        if ({busy, valid, done} !== 3'b000) begin
          n_errors++;
          $display("FAIL ignore_idle cyc=%0d got busy/valid/done=%b want 000", cyc, {busy, valid, done});
        end
      end
      @(posedge clock);
      #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    launch(4'd3);
    for (int cyc = 0; cyc < 3; cyc++) begin
      @(negedge clock);
      n_checks++;
      if (valid !== 1'b1 || busy !== 1'b1) begin
        n_errors++;
        $display("FAIL midreset_run cyc=%0d got valid=%b busy=%b want 1 1", cyc, valid, busy);
      end
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    n_checks++;
    if ({busy, valid, done} !== 3'b000 || selector !== 12'd0 || zero_select !== 4'd0) begin
      n_errors++;
      $display("FAIL midreset_idle got busy/valid/done=%b sel=%h zs=%b want 000 0 0",
               {busy, valid, done}, selector, zero_select);
    end
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(posedge clock);
      #1;
      @(negedge clock);
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_errors++;
        $display("FAIL midreset_no_done cyc=%0d got done=%b busy=%b want 0 0", cyc, done, busy);
      end
    end
  endtask

`ifdef SC_SEL_WRAP_EN
  task automatic test_wrap();
    logic [2:0] ws [4];
    logic       wz [4];
    ws = '{3'd1, 3'd0, 3'd1, 3'd0};
    wz = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    launch(4'd2);
    for (int j = 0; j < 12; j++) begin
      start = (j == 5);
      prec  = 4'd3;
      @(negedge clock);
      n_checks++;
      if (valid !== 1'b1 || busy !== 1'b1 || selector[2:0] !== ws[j % 4] || zero_select[0] !== wz[j % 4]) begin
        n_errors++;
        $display("FAIL wrap_seq j=%0d got valid=%b busy=%b sel0=%0d zs0=%b want 1 1 %0d %b",
                 j, valid, busy, selector[2:0], zero_select[0], ws[j % 4], wz[j % 4]);
      end
      n_checks++;
      if (done !== (j > 0 && (j % 4) == 0)) begin
        n_errors++;
        $display("FAIL wrap_done j=%0d got %b want %b", j, done, (j > 0 && (j % 4) == 0));
      end
      @(posedge clock);
      #1;
    end
    start = 1'b0;
  endtask
`endif

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    start    = 1'b0;
    enable   = 1'b0;
    prec     = 4'd0;
    test_reset();
`ifdef SC_SEL_WRAP_EN
    test_wrap();
    test_reset_mid();
`else
    test_basic();
    test_stall();
    test_prec_clamp();
    test_ignore_start();
    test_reset_mid();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
